// File: rtl/led_fx_pkg.sv
// led_fx_pkg: mode codes, register map and reset defaults shared by the led_fx_driver slice.
// Also holds the per-LED gating function so the effect rules live in one place.
package led_fx_pkg;

   typedef enum logic [1:0] {
      MODE_STEADY = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_PWM    = 2'b10,
      MODE_BOTH   = 2'b11
   } led_mode_e;

   typedef enum logic [1:0] {
      REG_MODE       = 2'd0,
      REG_DUTY       = 2'd1,
      REG_BLINK_HALF = 2'd2,
      REG_CTRL       = 2'd3
   } reg_addr_e;

   localparam logic [15:0] BLINK_HALF_RST   = 16'd500;
   localparam int          CTRL_RESTART_BIT = 0;
   localparam int          STATUS_PHASE_BIT = 16;

   // 1 when the LED may light this cycle given its mode and the shared effect sources.
   function automatic logic led_gate(input led_mode_e mode, input logic phase, input logic pwm_on);
      case (mode)
         MODE_STEADY: return 1'b1;
         MODE_BLINK:  return phase;
         MODE_PWM:    return pwm_on;
         default:     return phase & pwm_on;
      endcase
   endfunction

endpackage

// File: rtl/led_fx_if.sv
// led_fx_if: zero-wait-state Avalon-MM slave bus (s1) of led_fx_driver.
// readdata is combinational from address with read latency 0.
interface led_fx_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_fx_tick_gen.sv
// led_fx_tick_gen: blink-tick prescaler plus the blink half-period counter and phase.
// restart_i clears everything; blink_clr_i clears only the blink counter and phase.
module led_fx_tick_gen
   import led_fx_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        restart_i,
   input  logic        blink_clr_i,
   input  logic [15:0] blink_half_i,
   output logic        phase_o
);
   localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   blink_cnt_q, blink_cnt_d;
   logic [15:0]   half_last;
   logic          phase_q, phase_d;
   logic          tick;

   assign tick      = (presc_q == PRESC_LAST);
   assign half_last = (blink_half_i == 16'd0) ? 16'd0 : blink_half_i - 16'd1;
   assign phase_o   = phase_q;

   // NOTE: every _d gets its default first, so no path through this block infers a latch.
   always_comb begin
      presc_d     = tick ? '0 : presc_q + PW'(1);
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (restart_i) begin
         presc_d = '0;
      end
      // A clear in the same cycle as a tick wins; that tick is lost to the blink counter.
      if (restart_i || blink_clr_i) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (tick) begin
         if (blink_cnt_q == half_last) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 16'd1;
         end
      end
   end

   // NOTE: state is updated only with <= so every register samples the same pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q     <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else begin
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

endmodule

// File: rtl/led_fx_driver.sv
// led_fx_driver: per-LED steady/blink/PWM effects applied to PIO LED requests, configured via s1.
// Define LED_FX_ACTIVE_LOW_EN for current-sinking boards: led_out inverted, reset value all ones.
module led_fx_driver
   import led_fx_pkg::*;
#(
   parameter int NUM_LEDS = 4,
   parameter int PWM_W    = 8,
   parameter int TICK_DIV = 50000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_LEDS-1:0] pio_in,
   led_fx_if.slave             s1,
   output logic [NUM_LEDS-1:0] led_out
);
`ifdef LED_FX_ACTIVE_LOW_EN
   localparam logic [NUM_LEDS-1:0] LED_POL = '1;
`else
   localparam logic [NUM_LEDS-1:0] LED_POL = '0;
`endif

   logic [NUM_LEDS-1:0]   pio_q, led_out_q, led_out_d, led_state;
   logic [2*NUM_LEDS-1:0] mode_q, mode_d;
   logic [PWM_W-1:0]      duty_q, duty_d, pwm_cnt_q, pwm_cnt_d;
   logic [15:0]           blink_half_q, blink_half_d;
   logic                  wr, restart, blink_clr, phase, pwm_on;
   logic                  wdata_unused;

   assign wr           = s1.chipselect && !s1.write_n;
   assign restart      = wr && (s1.address == REG_CTRL) && s1.writedata[CTRL_RESTART_BIT];
   assign blink_clr    = wr && (s1.address == REG_BLINK_HALF);
   assign wdata_unused = ^s1.writedata;

   led_fx_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk          (clk),
      .reset_n      (reset_n),
      .restart_i    (restart),
      .blink_clr_i  (blink_clr),
      .blink_half_i (blink_half_q),
      .phase_o      (phase)
   );

   always_comb begin
      mode_d       = mode_q;
      duty_d       = duty_q;
      blink_half_d = blink_half_q;
      if (wr) begin
         case (s1.address)
            REG_MODE:       mode_d       = s1.writedata[2*NUM_LEDS-1:0];
            REG_DUTY:       duty_d       = s1.writedata[PWM_W-1:0];
            REG_BLINK_HALF: blink_half_d = s1.writedata[15:0];
            default:        ;
         endcase
      end
   end

   // Full-scale duty is pinned on so DUTY=all-ones really means 100%.
   assign pwm_cnt_d = restart ? '0 : pwm_cnt_q + PWM_W'(1);
   assign pwm_on    = (duty_q == '1) || (pwm_cnt_q < duty_q);

   always_comb begin
      led_out_d = LED_POL;
      for (int i = 0; i < NUM_LEDS; i++) begin
         led_out_d[i] = LED_POL[i] ^
                        (pio_q[i] & led_gate(led_mode_e'(mode_q[2*i +: 2]), phase, pwm_on));
      end
   end

   assign led_state = led_out_q ^ LED_POL;
   assign led_out   = led_out_q;

   always_comb begin
      s1.readdata = '0;
      case (s1.address)
         REG_MODE:       s1.readdata[2*NUM_LEDS-1:0] = mode_q;
         REG_DUTY:       s1.readdata[PWM_W-1:0]      = duty_q;
         REG_BLINK_HALF: s1.readdata[15:0]           = blink_half_q;
         default: begin
            s1.readdata[NUM_LEDS-1:0]    = led_state;
            s1.readdata[STATUS_PHASE_BIT] = phase;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pio_q        <= '0;
         led_out_q    <= LED_POL;
         mode_q       <= '0;
         duty_q       <= '1;
         blink_half_q <= BLINK_HALF_RST;
         pwm_cnt_q    <= '0;
      end else begin
         pio_q        <= pio_in;
         led_out_q    <= led_out_d;
         mode_q       <= mode_d;
         duty_q       <= duty_d;
         blink_half_q <= blink_half_d;
         pwm_cnt_q    <= pwm_cnt_d;
      end
   end

endmodule

// File: tb/tb_led_fx_driver.sv
// tb_led_fx_driver: scoreboard bench for led_fx_driver with a short blink tick (TICK_DIV=4).
// Expected LED/phase values are queued as stimulus is applied and popped as the DUT responds.
module tb_led_fx_driver;
   import led_fx_pkg::*;

   localparam int NUM_LEDS = 4;
   localparam int PWM_W    = 8;
   localparam int TICK_DIV = 4;
`ifdef LED_FX_ACTIVE_LOW_EN
   localparam logic [NUM_LEDS-1:0] LED_POL = '1;
`else
   localparam logic [NUM_LEDS-1:0] LED_POL = '0;
`endif
   localparam logic [31:0] RST_RD [4] = '{32'h0000_0000, 32'h0000_00FF, 32'h0000_01F4, 32'h0001_0000};

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NUM_LEDS-1:0] pio_in;
   logic [NUM_LEDS-1:0] led_out;

   int n_cmp = 0;
   int n_bad = 0;
   logic [NUM_LEDS-1:0] exp_led[$];
   logic                exp_phase[$];

   led_fx_if bus ();

   led_fx_driver #(.NUM_LEDS(NUM_LEDS), .PWM_W(PWM_W), .TICK_DIV(TICK_DIV)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .pio_in  (pio_in),
      .s1      (bus),
      .led_out (led_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Called just after a falling edge; the write lands on the next rising edge.
   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      bus.address    = addr;
      bus.writedata  = data;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
      bus.address = addr;
      #1;
      data = bus.readdata;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #12;
      n_cmp++;
      if (led_out !== LED_POL) begin
         n_bad++;
         $display("FAIL reset_led_out: got %b expected %b", led_out, LED_POL);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a), rd);
         n_cmp++;
         if (rd !== RST_RD[a]) begin
            n_bad++;
            $display("FAIL reset_read_addr%0d: got %h expected %h", a, rd, RST_RD[a]);
         end
      end
   endtask

   task automatic test_pipeline();
      logic [NUM_LEDS-1:0] pat [10] = '{4'b1010, 4'b1010, 4'b1010, 4'b0101, 4'b1111,
                                        4'b1111, 4'b0000, 4'b0110, 4'b0110, 4'b0110};
      logic [NUM_LEDS-1:0] exp, got;
      exp_led.delete();
      exp_led.push_back(pio_in);
      exp_led.push_back(pio_in);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         got = led_out ^ LED_POL;
         exp = exp_led.pop_front();
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL pipeline_cycle%0d: got %b expected %b", k, got, exp);
         end
         if (k < 10) begin
            pio_in = pat[k];
            exp_led.push_back(pat[k]);
         end
      end
   endtask

   task automatic test_blink();
      logic [NUM_LEDS-1:0] exp, got;
      logic [31:0] rd;
      logic ph;
      pio_in = 4'b1111;
      bus_write(REG_MODE, 32'h01);
      bus_write(REG_BLINK_HALF, 32'd2);
      bus_write(REG_CTRL, 32'h1);
      exp_led.delete();
      exp_phase.delete();
      for (int j = 1; j <= 48; j++) begin
         exp_led.push_back({3'b111, ((j - 1) / 8) % 2 == 0});
         exp_phase.push_back((j / 8) % 2 == 0);
      end
      for (int j = 1; j <= 48; j++) begin
         @(negedge clk);
         got = led_out ^ LED_POL;
         exp = exp_led.pop_front();
         ph  = exp_phase.pop_front();
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL blink_led_cycle%0d: got %b expected %b", j, got, exp);
         end
         bus_read(REG_CTRL, rd);
         n_cmp++;
         if (rd !== {15'b0, ph, 12'b0, exp}) begin
            n_bad++;
            $display("FAIL blink_status_cycle%0d: got %h expected %h", j, rd, {15'b0, ph, 12'b0, exp});
         end
      end
   endtask

   task automatic test_blink_half_zero();
      logic [31:0] rd;
      logic ph;
      bus_write(REG_BLINK_HALF, 32'd0);
      bus_write(REG_CTRL, 32'h1);
      exp_phase.delete();
      for (int j = 0; j < 24; j++) exp_phase.push_back((j / 4) % 2 == 0);
      for (int j = 0; j < 24; j++) begin
         if (j > 0) @(negedge clk);
         bus_read(REG_CTRL, rd);
         ph = exp_phase.pop_front();
         n_cmp++;
         if (rd[16] !== ph) begin
            n_bad++;
            $display("FAIL half0_phase_cycle%0d: got %b expected %b", j, rd[16], ph);
         end
      end
   endtask

   // BLINK_HALF write lands on a toggling tick, then a restart lands while phase is off.
   task automatic test_write_on_tick();
      logic [31:0] rd;
      logic ph;
      bus_write(REG_BLINK_HALF, 32'd2);
      bus_write(REG_CTRL, 32'h1);
      exp_phase.delete();
      for (int j = 1; j <= 28; j++)
         exp_phase.push_back((j < 16) ? 1'b1 : (j < 20) ? 1'b0 : (j < 28) ? 1'b1 : 1'b0);
      for (int j = 1; j <= 28; j++) begin
         if (j != 8 && j != 20) @(negedge clk);
         bus_read(REG_CTRL, rd);
         ph = exp_phase.pop_front();
         n_cmp++;
         if (rd[16] !== ph) begin
            n_bad++;
            $display("FAIL tick_collide_phase_cycle%0d: got %b expected %b", j, rd[16], ph);
         end
         if (j == 7)  bus_write(REG_BLINK_HALF, 32'd2);
         if (j == 19) bus_write(REG_CTRL, 32'h1);
      end
   endtask

   task automatic run_pwm(input logic [7:0] duty, input int exp_cnt);
      logic [NUM_LEDS-1:0] exp, got;
      int highs = 0;
      bus_write(REG_DUTY, {24'b0, duty});
      bus_write(REG_CTRL, 32'h1);
      exp_led.delete();
      for (int j = 1; j <= 256; j++)
         exp_led.push_back({2'b00, (duty == 8'hFF) || (8'((j - 1) % 256) < duty), 1'b0});
      for (int j = 1; j <= 256; j++) begin
         @(negedge clk);
         got = led_out ^ LED_POL;
         exp = exp_led.pop_front();
         if (got[1]) highs++;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL pwm_duty%0d_cycle%0d: got %b expected %b", duty, j, got, exp);
         end
      end
      n_cmp++;
      if (highs != exp_cnt) begin
         n_bad++;
         $display("FAIL pwm_duty%0d_count: got %0d expected %0d", duty, highs, exp_cnt);
      end
   endtask

   task automatic test_pwm();
      pio_in = 4'b0010;
      bus_write(REG_MODE, 32'h08);
      run_pwm(8'd64, 64);
      run_pwm(8'd0, 0);
      run_pwm(8'd255, 256);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      @(negedge clk);
      n_cmp++;
      if ((led_out ^ LED_POL) !== 4'b0010) begin
         n_bad++;
         $display("FAIL pre_reset_led: got %b expected %b", led_out ^ LED_POL, 4'b0010);
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (led_out !== LED_POL) begin
         n_bad++;
         $display("FAIL async_reset_led: got %b expected %b", led_out, LED_POL);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 3; a++) begin
         bus_read(2'(a), rd);
         n_cmp++;
         if (rd !== RST_RD[a]) begin
            n_bad++;
            $display("FAIL post_reset_read_addr%0d: got %h expected %h", a, rd, RST_RD[a]);
         end
      end
   endtask

   initial begin
      pio_in         = '0;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      test_reset();
      test_pipeline();
      test_blink();
      test_blink_half_zero();
      test_write_on_tick();
      test_pwm();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
